delivery_speed_scheduler: RTL and testbench
===========================================

// Module: delivery_speed_scheduler
// PURPOSE
//  Sequences the delivery game datapath while a match runs. Polls the ultrasonic
//  speed measurement (get_velocity / velocity_ready handshake) and turns the
//  measured speed level into the map-advance strobe (count_map).
//  Sits between delivery_game_uc (supplies enable) and delivery_game_fd
//  (consumes get_velocity and count_map, returns velocity_ready and level).
// PARAMETERS
//  BASE_PERIOD    50_000_000  map-advance period at level 0, in clocks
//  STEP           5_000_000   period reduction per speed level, in clocks
//  SAMPLE_PERIOD  12_500_000  clocks spent in RUN between measurement requests
//  TIMEOUT        2_500_000   max clocks waiting for velocity_ready
//  CW             32          counter width; must hold every parameter above
//  Constraint: BASE_PERIOD > 7*STEP; all periods >= 2.
// PORTS
//  clock           in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  enable          in   1   match running; low returns the block to IDLE
//  velocity_ready  in   1   1-cycle pulse: measurement valid on vel_level
//  vel_level       in   3   speed level 0..7, valid while velocity_ready=1
//  get_velocity    out  1   1-cycle measurement request pulse
//  count_map       out  1   1-cycle map-advance strobe
//  level           out  3   speed level in use
//  timeout         out  1   last request got no reply
//  estado          out  2   FSM state: IDLE=0, REQ=1, WAIT=2, RUN=3
// BEHAVIOUR
//  Reset, or enable=0 in any state: next cycle is IDLE.
//    All counters, level, timeout, started, get_velocity and count_map = 0.
//    Reset mid-operation behaves the same way.
//  FSM
//   IDLE: enable=1 -> REQ.
//   REQ: get_velocity=1 for exactly this cycle; wait counter cleared -> WAIT.
//   WAIT: wait counter increments each cycle.
//     velocity_ready=1 -> level<=vel_level, timeout<=0, started<=1 -> RUN.
//     Else wait counter==TIMEOUT-1 -> timeout<=1, level unchanged,
//       started<=1 -> RUN.
//     velocity_ready in the same cycle as expiry: the measurement wins.
//   RUN: sample counter counts 0..SAMPLE_PERIOD-1; at terminal -> clear, go to REQ.
//  velocity_ready outside WAIT is ignored (no level change).
//  Scroll timer
//   period = BASE_PERIOD - level*STEP, in CW-bit unsigned arithmetic.
//   Runs only while started=1 and state != IDLE, including REQ and WAIT.
//   Counts up each cycle. When count >= period-1: count_map=1 for one cycle,
//     count<=0.
//   A level change mid-count applies immediately; a count already past the
//     new terminal fires on the next cycle.
//  Outputs are registered; get_velocity and count_map are never high 2 cycles
//   in a row.
//  First count_map comes a full period after started rises; nothing scrolls
//   before the first measurement or timeout.
// TESTING (bench params: BASE=20 STEP=2 SAMPLE=50 TIMEOUT=8 CW=8)
//  1 reset, enable=1 -> estado 0,1,2; get_velocity high 1 cycle only; count_map
//    stays 0 while in WAIT with no reply.
//  2 reply level=0 on 3rd WAIT cycle -> RUN; count_map every 20 clocks; REQ
//    reached after 50 RUN cycles.
//  3 next reply level=7 -> count_map spacing becomes 6; if count>=5 at the
//    change, strobe on the next cycle.
//  4 no reply -> timeout=1 after 8 WAIT cycles, level held, RUN entered;
//    a later reply clears timeout.
//  5 velocity_ready on the expiry cycle -> level updated, timeout stays 0;
//    ready pulse in RUN -> level unchanged.
//  6 enable=0 or reset mid-WAIT and mid-scroll -> next cycle estado=0, all
//    outputs 0; re-enable restarts at REQ with started=0.

Source files
------------

// File: rtl/delivery_speed_scheduler.sv
// delivery_speed_scheduler: polls the speed sensor and turns the measured
// level into a periodic map-advance strobe while a match is running.
// Ports: clock, reset (sync, active-high), enable, velocity_ready, vel_level[2:0]
//        -> get_velocity, count_map, level[2:0], timeout, estado[1:0].
module delivery_speed_scheduler #(
    parameter int unsigned BASE_PERIOD   = 50_000_000,
    parameter int unsigned STEP          = 5_000_000,
    parameter int unsigned SAMPLE_PERIOD = 12_500_000,
    parameter int unsigned TIMEOUT       = 2_500_000,
    parameter int unsigned CW            = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       velocity_ready,
    input  logic [2:0] vel_level,
    output logic       get_velocity,
    output logic       count_map,
    output logic [2:0] level,
    output logic       timeout,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE_PERIOD - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] scroll_cnt;
    logic [CW-1:0] period;
    logic          started;
    logic          got_reply;
    logic          expired;
    logic          sample_done;

    assign estado = state;

    // Period follows the current level combinationally, so a level change
    // shortens the running count right away.
    assign period = CW'(BASE_PERIOD) - CW'(level) * CW'(STEP);

    always_comb begin
        state_next  = state;
        got_reply   = 1'b0;
        expired     = 1'b0;
        sample_done = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ:  state_next = WAIT;
            WAIT: begin
                // A reply on the expiry cycle takes priority over timing out.
                if (velocity_ready) begin
                    got_reply  = 1'b1;
                    state_next = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    expired    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (sample_cnt == SAMP_LAST) begin
                    sample_done = 1'b1;
                    state_next  = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            sample_cnt   <= '0;
            scroll_cnt   <= '0;
            started      <= 1'b0;
            level        <= 3'd0;
            timeout      <= 1'b0;
            get_velocity <= 1'b0;
            count_map    <= 1'b0;
        end else begin
            state        <= state_next;
            get_velocity <= (state_next == REQ);

            case (state)
                REQ:     wait_cnt <= '0;
                WAIT:    wait_cnt <= wait_cnt + ONE;
                default: ;
            endcase

            if (got_reply) begin
                level   <= vel_level;
                timeout <= 1'b0;
                started <= 1'b1;
            end else if (expired) begin
                timeout <= 1'b1;
                started <= 1'b1;
            end

            if (state == RUN) begin
                sample_cnt <= sample_done ? '0 : sample_cnt + ONE;
            end

            // Scroll keeps running through REQ/WAIT once the first
            // measurement (or timeout) has happened.
            count_map <= 1'b0;
            if (started && state != IDLE) begin
                if (scroll_cnt >= period - ONE) begin
                    count_map  <= 1'b1;
                    scroll_cnt <= '0;
                end else begin
                    scroll_cnt <= scroll_cnt + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_delivery_speed_scheduler.sv
// tb_delivery_speed_scheduler: directed stimulus with queued expected
// strobe times, checked by an independent monitor on the falling edge.
module tb_delivery_speed_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       velocity_ready;
    logic [2:0] vel_level;
    logic       get_velocity;
    logic       count_map;
    logic [2:0] level;
    logic       timeout;
    logic [1:0] estado;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    bit mon_on   = 1'b0;
    int gv_q[$];
    int cm_q[$];

    delivery_speed_scheduler #(
        .BASE_PERIOD(20),
        .STEP(2),
        .SAMPLE_PERIOD(50),
        .TIMEOUT(8),
        .CW(8)
    ) dut (
        .clock(clk),
        .reset(reset),
        .enable(enable),
        .velocity_ready(velocity_ready),
        .vel_level(vel_level),
        .get_velocity(get_velocity),
        .count_map(count_map),
        .level(level),
        .timeout(timeout),
        .estado(estado)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic cmp(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d (r=%0d)",
                     name, act, exp, cyc - t0);
        end
    endtask

    task automatic wait_r(input int n);
        while ((cyc - t0) < n) @(negedge clk);
    endtask

    task automatic pulse_ready(input logic [2:0] lvl);
        velocity_ready = 1'b1;
        vel_level      = lvl;
        @(negedge clk);
        velocity_ready = 1'b0;
        vel_level      = 3'd0;
    endtask

    // Monitor: every strobe pops its expected cycle stamp.
    always @(negedge clk) begin
        if (mon_on) begin
            if (get_velocity) begin
                if (gv_q.size() == 0) begin
                    cmp("gv_unexpected", cyc - t0, -1);
                end else begin
                    cmp("gv_cycle", cyc - t0, gv_q.pop_front());
                end
            end
            if (count_map) begin
                if (cm_q.size() == 0) begin
                    cmp("cm_unexpected", cyc - t0, -1);
                end else begin
                    cmp("cm_cycle", cyc - t0, cm_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        velocity_ready = 1'b0;
        vel_level      = 3'd0;
        repeat (3) @(negedge clk);
        cmp("rst_estado", estado, 0);
        cmp("rst_gv", get_velocity, 0);
        cmp("rst_cm", count_map, 0);
        cmp("rst_level", level, 0);
        cmp("rst_timeout", timeout, 0);

        // Start: REQ at r=1, reply level 0 on 3rd WAIT cycle.
        gv_q.push_back(1);
        gv_q.push_back(55);
        cm_q.push_back(25);
        cm_q.push_back(45);
        t0     = cyc;
        mon_on = 1'b1;
        reset  = 1'b0;
        wait_r(1);
        cmp("s1_req", estado, 1);
        wait_r(2);
        cmp("s1_wait", estado, 2);
        cmp("s1_gv_low", get_velocity, 0);
        wait_r(4);
        pulse_ready(3'd0);
        cmp("s2_run", estado, 3);
        cmp("s2_level", level, 0);

        // Level 7 reply: count already past new terminal -> fires at 58.
        wait_r(56);
        cmp("s3_wait", estado, 2);
        for (int c = 58; c <= 172; c += 6) cm_q.push_back(c);
        gv_q.push_back(107);
        gv_q.push_back(166);
        pulse_ready(3'd7);
        cmp("s3_level", level, 7);
        cmp("s3_run", estado, 3);

        // No reply: timeout after 8 WAIT cycles.
        wait_r(115);
        cmp("s4_wait", estado, 2);
        cmp("s4_to_pre", timeout, 0);
        wait_r(116);
        cmp("s4_run", estado, 3);
        cmp("s4_to", timeout, 1);
        cmp("s4_level", level, 7);

        // Reply on the expiry cycle wins and clears timeout.
        wait_r(174);
        cm_q.push_back(186);
        cm_q.push_back(200);
        cm_q.push_back(214);
        gv_q.push_back(225);
        pulse_ready(3'd3);
        cmp("s5_level", level, 3);
        cmp("s5_to", timeout, 0);
        cmp("s5_run", estado, 3);

        // Ready pulse during RUN is ignored.
        wait_r(190);
        pulse_ready(3'd0);
        wait_r(192);
        cmp("s5_ign_level", level, 3);

        // enable low mid-WAIT while scrolling.
        wait_r(227);
        enable = 1'b0;
        wait_r(228);
        cmp("s6_en_estado", estado, 0);
        cmp("s6_en_level", level, 0);
        cmp("s6_en_to", timeout, 0);
        cmp("s6_en_gv", get_velocity, 0);
        cmp("s6_en_cm", count_map, 0);

        // Re-enable: restarts at REQ with no scroll until timeout.
        wait_r(230);
        gv_q.push_back(231);
        cm_q.push_back(260);
        enable = 1'b1;
        wait_r(231);
        cmp("s6_re_req", estado, 1);
        wait_r(240);
        cmp("s6_re_run", estado, 3);
        cmp("s6_re_to", timeout, 1);
        cmp("s6_re_level", level, 0);

        // Reset mid-scroll.
        wait_r(265);
        reset = 1'b1;
        wait_r(266);
        cmp("s6_rst_estado", estado, 0);
        cmp("s6_rst_to", timeout, 0);
        cmp("s6_rst_cm", count_map, 0);
        wait_r(268);
        gv_q.push_back(269);
        reset = 1'b0;
        wait_r(269);
        cmp("s6_rst_req", estado, 1);

        wait_r(285);
        cmp("gv_left", gv_q.size(), 0);
        cmp("cm_left", cm_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
